// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//   Shared constants for the RISC-V front end. This package holds:
//     - the fetch FSM state encoding (FETCH, HOLD, FAULT),
//     - the default reset PC,
//     - the canonical NOP encoding (addi x0, x0, 0),
//     - the sequential PC increment.
//   FAULT is only reachable when FETCH_MISALIGN_TRAP_EN is defined at build time.
// ----------------------------------------------------------------------------
package riscv_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FETCH = 2'd0;
  localparam fetch_state_t HOLD  = 2'd1;
  localparam fetch_state_t FAULT = 2'd2;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam int unsigned PC_INCR          = 4;

endpackage

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage of the RISC-V core. It owns the fetch PC and issues one
//   outstanding word read at a time to instruction memory. The returned word
//   is held together with its PC until decode accepts it. Taken branches and
//   jumps redirect the fetch PC; a response that belongs to the abandoned path
//   is consumed and dropped.
//
//   Build option:
//     FETCH_MISALIGN_TRAP_EN  defined   -> a redirect whose target[1:0] != 0
//                                          parks the unit in FAULT (fault = 1)
//                                          until reset or an aligned redirect.
//                             undefined -> target[1:0] is forced to 0 and
//                                          fault is tied low.
//
//   Ports:
//     clk, reset          single rising-edge clock, synchronous active-high reset
//     imem_req/imem_addr  word-aligned read request, held stable until rvalid
//     imem_rvalid/rdata   read response (may arrive in the request cycle)
//     instr_valid/ready   handshake towards decode
//     instr, pc, pc_plus4 held instruction, its PC, and PC + 4 (modulo 2^32)
//     redirect/target     taken branch or jump and its target
//     fault               misaligned redirect target trap
// ----------------------------------------------------------------------------
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  output logic                  fault
);

  fetch_state_t          state_q,       state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q,    fetch_pc_d;
  // Address of the request currently on the bus. It differs from fetch_pc
  // only while a redirected-away response is still outstanding.
  logic [DATA_WIDTH-1:0] addr_q,        addr_d;
  logic                  discard_q,     discard_d;
  logic                  instr_valid_q, instr_valid_d;
  logic [DATA_WIDTH-1:0] instr_q,       instr_d;
  logic [DATA_WIDTH-1:0] pc_q,          pc_d;

  logic [DATA_WIDTH-1:0] tgt_aligned;
  assign tgt_aligned = {redirect_target[DATA_WIDTH-1:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  logic tgt_misaligned;
  assign tgt_misaligned = |redirect_target[1:0];
  assign fault          = fault_q;
`else
  // The low target bits are ignored in this build.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^redirect_target[1:0];
  assign fault              = 1'b0;
`endif

  // Request is combinational on state so it drops in the reset cycle itself.
  assign imem_req    = (state_q == FETCH) && !reset;
  assign imem_addr   = addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + DATA_WIDTH'(PC_INCR);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    addr_d        = addr_q;
    discard_d     = discard_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d       = fault_q;
`endif

    case (state_q)
      FETCH: begin
        if (redirect) begin
          // A response arriving this cycle belongs to the old path and is
          // dropped here; otherwise the pending one must be dropped later.
          // Repeated redirects keep a single discard pending.
          discard_d = ~imem_rvalid;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (tgt_misaligned) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else
`endif
          begin
            fetch_pc_d = tgt_aligned;
            // The bus address may only move once the old request completed.
            if (imem_rvalid) begin
              addr_d = tgt_aligned;
            end
          end
        end else if (imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            addr_d    = fetch_pc_q;
          end else begin
            instr_d       = imem_rdata;
            pc_d          = addr_q;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          // Held instruction is squashed, never counted as accepted.
          instr_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (tgt_misaligned) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else
`endif
          begin
            fetch_pc_d = tgt_aligned;
            addr_d     = tgt_aligned;
            state_d    = FETCH;
          end
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          fetch_pc_d    = pc_plus4;
          addr_d        = pc_plus4;
          state_d       = FETCH;
        end
      end

`ifdef FETCH_MISALIGN_TRAP_EN
      FAULT: begin
        // A response still outstanding from before the trap is swallowed.
        if (imem_rvalid) begin
          discard_d = 1'b0;
        end
        if (redirect && !tgt_misaligned) begin
          state_d    = FETCH;
          fault_d    = 1'b0;
          fetch_pc_d = tgt_aligned;
          // If the old response is still due, keep its address on the bus;
          // FETCH retargets once it has been dropped.
          if (!discard_q || imem_rvalid) begin
            addr_d = tgt_aligned;
          end
        end
      end
`endif

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      addr_q        <= RESET_PC;
      discard_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= DATA_WIDTH'(INSTR_NOP);
      pc_q          <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      addr_q        <= addr_d;
      discard_q     <= discard_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q       <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. Inputs are driven 1 time unit after
//   the rising edge and outputs are sampled 1 time unit later, i.e. each row
//   shows the inputs of a cycle together with the outputs of that cycle.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .fault           (fault)
  );

  typedef struct {
    logic        rst;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        chk_data;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic rdr, input logic [31:0] tg);
    reset           = rst;
    imem_rvalid     = rv;
    imem_rdata      = rd;
    instr_ready     = rdy;
    redirect        = rdr;
    redirect_target = tg;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst rv rdata          rdy rdr tgt    e_req e_addr        e_val chk e_instr        e_pc
    vt[0] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b0, RPC,           1'b0, 1'b1, NOP,           RPC};
    vt[1] = '{1'b0, 1'b1, 32'h0050_0093, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0040_0000, 1'b0, 1'b0, 32'h0,         32'h0};
    vt[2] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0050_0093, 32'h0040_0000};
    vt[3] = '{1'b0, 1'b1, 32'h00A0_0113, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0040_0004, 1'b0, 1'b0, 32'h0,         32'h0};
    vt[4] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00A0_0113, 32'h0040_0004};
    vt[5] = '{1'b0, 1'b1, 32'h0020_81B3, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0040_0008, 1'b0, 1'b0, 32'h0,         32'h0};
    vt[6] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0020_81B3, 32'h0040_0008};

    // Initial reset cycle brings the DUT out of X; row 0 then checks reset state.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();

    // Zero-wait memory, decode always ready: one instruction every 2 cycles.
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].rst, vt[i].rvalid, vt[i].rdata, vt[i].ready, vt[i].redir, vt[i].tgt);
      chk($sformatf("v%0d imem_req", i), 32'(imem_req), 32'(vt[i].e_req));
      chk($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vt[i].e_valid));
      chk($sformatf("v%0d fault", i), 32'(fault), 32'h0);
      if (vt[i].e_req || vt[i].rst)
        chk($sformatf("v%0d imem_addr", i), imem_addr, vt[i].e_addr);
      if (vt[i].chk_data) begin
        chk($sformatf("v%0d instr", i), instr, vt[i].e_instr);
        chk($sformatf("v%0d pc", i), pc, vt[i].e_pc);
        chk($sformatf("v%0d pc_plus4", i), pc_plus4, vt[i].e_pc + 32'd4);
      end
      tick();
    end

    // 3-cycle memory wait, then decode stalls for 4 cycles.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk($sformatf("wait%0d imem_req", c), 32'(imem_req), 32'h1);
      chk($sformatf("wait%0d imem_addr", c), imem_addr, RPC);
      tick();
    end
    drive(1'b0, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 32'h0);
    chk("wait3 imem_addr", imem_addr, RPC);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk($sformatf("stall%0d instr_valid", c), 32'(instr_valid), 32'h1);
      chk($sformatf("stall%0d instr", c), instr, 32'h0010_0093);
      chk($sformatf("stall%0d pc", c), pc, RPC);
      chk($sformatf("stall%0d imem_req", c), 32'(imem_req), 32'h0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("accept instr_valid", 32'(instr_valid), 32'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("after_accept instr_valid", 32'(instr_valid), 32'h0);
    chk("after_accept imem_req", 32'(imem_req), 32'h1);
    chk("after_accept imem_addr", imem_addr, 32'h0040_0004);

    // Two redirects while waiting: last one wins, one response dropped.
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0080);
    chk("redirA imem_addr", imem_addr, RPC);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0100);
    chk("redirB imem_addr", imem_addr, RPC);
    tick();
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    chk("stale_resp imem_addr", imem_addr, RPC);
    chk("stale_resp imem_req", 32'(imem_req), 32'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("dropped instr_valid", 32'(instr_valid), 32'h0);
    chk("retarget imem_req", 32'(imem_req), 32'h1);
    chk("retarget imem_addr", imem_addr, 32'h0040_0100);
    tick();
    drive(1'b0, 1'b1, 32'h0040_0213, 1'b1, 1'b0, 32'h0);
    chk("new_resp imem_addr", imem_addr, 32'h0040_0100);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("new_resp instr_valid", 32'(instr_valid), 32'h1);
    chk("new_resp instr", instr, 32'h0040_0213);
    chk("new_resp pc", pc, 32'h0040_0100);

    // Redirect in HOLD together with instr_ready: target wins over pc + 4.
    do_reset();
    drive(1'b0, 1'b1, 32'h0030_0193, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0200);
    chk("hold_redir instr_valid", 32'(instr_valid), 32'h1);
    chk("hold_redir pc", pc, RPC);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("hold_redir squash", 32'(instr_valid), 32'h0);
    chk("hold_redir imem_req", 32'(imem_req), 32'h1);
    chk("hold_redir imem_addr", imem_addr, 32'h0040_0200);

    // Redirect coinciding with rvalid, then PC wrap at 0xFFFF_FFFC.
    do_reset();
    drive(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    drive(1'b0, 1'b1, 32'h0000_0073, 1'b0, 1'b0, 32'h0);
    chk("wrap_fetch instr_valid", 32'(instr_valid), 32'h0);
    chk("wrap_fetch imem_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("wrap_hold instr_valid", 32'(instr_valid), 32'h1);
    chk("wrap_hold instr", instr, 32'h0000_0073);
    chk("wrap_hold pc", pc, 32'hFFFF_FFFC);
    chk("wrap_hold pc_plus4", pc_plus4, 32'h0000_0000);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("wrap_next imem_req", 32'(imem_req), 32'h1);
    chk("wrap_next imem_addr", imem_addr, 32'h0000_0000);

    // Misaligned redirect target while a request is outstanding.
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0102);
    chk("mis_redir imem_addr", imem_addr, RPC);
    tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    drive(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
    chk("mis_fault fault", 32'(fault), 32'h1);
    chk("mis_fault imem_req", 32'(imem_req), 32'h0);
    chk("mis_fault instr_valid", 32'(instr_valid), 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0100);
    chk("mis_fault_held fault", 32'(fault), 32'h1);
    chk("mis_fault_held imem_req", 32'(imem_req), 32'h0);
    tick();
    drive(1'b0, 1'b1, 32'h0050_0293, 1'b0, 1'b0, 32'h0);
    chk("mis_resume fault", 32'(fault), 32'h0);
    chk("mis_resume imem_req", 32'(imem_req), 32'h1);
    chk("mis_resume imem_addr", imem_addr, 32'h0040_0100);
    tick();
`else
    drive(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
    chk("mis_stale fault", 32'(fault), 32'h0);
    chk("mis_stale imem_req", 32'(imem_req), 32'h1);
    chk("mis_stale imem_addr", imem_addr, RPC);
    tick();
    drive(1'b0, 1'b1, 32'h0050_0293, 1'b0, 1'b0, 32'h0);
    chk("mis_fetch instr_valid", 32'(instr_valid), 32'h0);
    chk("mis_fetch imem_req", 32'(imem_req), 32'h1);
    chk("mis_fetch imem_addr", imem_addr, 32'h0040_0100);
    tick();
`endif
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("mis_done instr_valid", 32'(instr_valid), 32'h1);
    chk("mis_done instr", instr, 32'h0050_0293);
    chk("mis_done pc", pc, 32'h0040_0100);
    chk("mis_done fault", 32'(fault), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the RISC-V core; sits directly upstream of the immediate generator and decoder.
- Owns the PC and issues single-outstanding word reads to instruction memory.
- Holds the returned instruction with its PC until the decode stage accepts it.
- Accepts PC redirects for taken branches and jumps; the target is computed downstream from the extended immediate.

Parameters:
- RESET_PC, 32'h0040_0000, PC loaded on reset.
- DATA_WIDTH, 32, instruction and address width.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  read request to instruction memory
- imem_addr  out  DATA_WIDTH  word address of the outstanding request
- imem_rvalid  in  1  read data valid; may assert in the same cycle as imem_req or any later cycle
- imem_rdata  in  DATA_WIDTH  instruction word
- instr_valid  out  1  held instruction available to decode
- instr_ready  in  1  decode accepts the instruction this cycle
- instr  out  DATA_WIDTH  held instruction word
- pc  out  DATA_WIDTH  PC of the held instruction
- pc_plus4  out  DATA_WIDTH  pc + 4
- redirect  in  1  taken branch or jump
- redirect_target  in  DATA_WIDTH  new PC
- fault  out  1  misaligned-target fault (see Optional Feature)

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high. Reset applies on the edge only and has priority over everything, including mid-request.
- Reset values:
  - fetch_pc = RESET_PC
  - state = FETCH
  - imem_req = 0 during the reset cycle, 1 from the first cycle after reset
  - instr_valid = 0, instr = 32'h0000_0013 (NOP), pc = RESET_PC, fault = 0, discard = 0
- States: FETCH, HOLD, FAULT (FAULT only when the feature is compiled in).
- FETCH:
  - imem_req = 1 and imem_addr = fetch_pc; both stay stable until imem_rvalid.
  - On rvalid with discard = 0: capture instr = imem_rdata and pc = fetch_pc, set instr_valid = 1, go to HOLD. Latency is 1 cycle from rvalid to instr_valid.
  - On rvalid with discard = 1: drop the data, clear discard, stay in FETCH. The new request to fetch_pc starts the next cycle.
- HOLD:
  - imem_req = 0; instr, pc and instr_valid are held stable.
  - On instr_valid & instr_ready: instr_valid = 0, fetch_pc = pc + 4, go to FETCH.
  - Throughput is one instruction per 2 cycles with zero-wait memory.
- Redirect has priority over both handshakes in the same cycle.
  - In HOLD: the held instruction is invalidated (instr_valid = 0 next cycle, not counted as accepted), fetch_pc = target, go to FETCH.
  - In FETCH without rvalid: fetch_pc = target and discard = 1. The pending request keeps its old address until rvalid arrives.
  - In FETCH with rvalid in the same cycle: drop the data, fetch_pc = target, discard stays 0.
  - Multiple redirects while discard = 1: the last target wins, and only one response is discarded.
- Arithmetic:
  - pc + 4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0 with no flag.
  - imem_addr is always word-aligned.
- Redirect targets with target[1:0] != 0 are handled per Optional Feature.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with target[1:0] != 0 enters FAULT next cycle, with fault = 1, imem_req = 0, instr_valid = 0.
  - An outstanding response is still consumed and dropped.
  - FAULT exits only on reset, or on a redirect with an aligned target, which goes to FETCH with fault = 0.
- Undefined: target[1:0] is forced to 0, fault is tied 0, and the FAULT state does not exist.

Decomposition:
- Shared package riscv_pkg holds:
  - state encoding: FETCH = 2'd0, HOLD = 2'd1, FAULT = 2'd2
  - RESET_PC default
  - INSTR_NOP = 32'h0000_0013
  - PC_INCR = 4
- No sub-module: FSM, PC register, instruction register and discard flag live in one module, about 150–250 lines.

Test Plan:
- Reset then zero-wait memory returning 32'h0050_0093 at 0x0040_0000, instr_ready = 1:
  - instr_valid rises 1 cycle after rvalid with pc = 0x0040_0000.
  - Next request is issued at 0x0040_0004; one instruction every 2 cycles.
- 3-cycle memory wait and instr_ready held low for 4 cycles:
  - imem_addr is stable throughout the wait.
  - instr and pc are stable while valid and not ready.
  - No second request is issued.
- Redirect to 0x0040_0100 while in FETCH waiting:
  - The old response arrives and is dropped, with no instr_valid.
  - The next request goes to 0x0040_0100.
- Redirect in HOLD in the same cycle as instr_ready = 1:
  - instr_valid = 0 next cycle; fetch goes to the target, not pc + 4.
- fetch_pc = 0xFFFF_FFFC accepted: the next imem_addr is 0x0000_0000.
- Redirect to 0x0040_0102:
  - With FETCH_MISALIGN_TRAP_EN: fault = 1, imem_req = 0; a subsequent aligned redirect resumes fetch.
  - Without it: fetch proceeds at 0x0040_0100.
